branch_resolve_ctrl: RTL

//  Decode-stage sequencer for the early-branch comparator (Branch_D codes 001..110).

---
 rtl/mips_pkg.sv | 34 +++
 rtl/branch_hazard_detect.sv | 53 +++++
 rtl/branch_resolve_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the decode-stage branch logic.
//   Branch_D codes (3 bits), FSM state encoding for the branch sequencer,
//   and default widths for the statistics counters and register specifiers.
package mips_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BLTZ = 3'b001;
    localparam logic [2:0] BR_BGEZ = 3'b010;
    localparam logic [2:0] BR_BEQ  = 3'b011;
    localparam logic [2:0] BR_BNE  = 3'b100;
    localparam logic [2:0] BR_BLEZ = 3'b101;
    localparam logic [2:0] BR_BGTZ = 3'b110;
    localparam logic [2:0] BR_RSVD = 3'b111;

    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned REG_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_STALL1  = 2'b01,
        ST_RESOLVE = 2'b10
    } br_state_e;

    // Codes 001..110 are real branches; 000 and 111 are not.
    function automatic logic is_branch(input logic [2:0] code);
        return (code != BR_NONE) && (code != BR_RSVD);
    endfunction

    // Only the two-register compares read rt.
    function automatic logic uses_rt(input logic [2:0] code);
        return (code == BR_BEQ) || (code == BR_BNE);
    endfunction

endpackage

// File: rtl/branch_hazard_detect.sv
// Combinational RAW-hazard check for the early-branch comparator operands.
//   branch_d            : branch code in decode
//   rs_d / rt_d         : branch operand registers
//   ex_* / mem_*        : write-back intent of the EX and MEM stage instructions
//   need_o              : stall cycles required (0, 1 or 2)
//   fwd_a_d / fwd_b_d   : take operand A / B from the MEM-stage ALU result
module branch_hazard_detect
    import mips_pkg::*;
#(
    parameter int unsigned REG_W = REG_W_DEF
) (
    input  logic [2:0]       branch_d,
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic             ex_regwrite,
    input  logic             ex_memtoreg,
    input  logic [REG_W-1:0] ex_wreg,
    input  logic             mem_regwrite,
    input  logic             mem_memtoreg,
    input  logic [REG_W-1:0] mem_wreg,
    output logic [1:0]       need_o,
    output logic             fwd_a_d,
    output logic             fwd_b_d
);

    logic rt_used;
    logic m_ex;
    logic m_mem;
    logic mem_a_hit;
    logic mem_b_hit;

    always_comb begin
        rt_used   = uses_rt(branch_d);
        // Register 0 is hard-wired, so a write to it never creates a hazard.
        m_ex      = ex_regwrite && (ex_wreg != '0) &&
                    ((ex_wreg == rs_d) || (rt_used && (ex_wreg == rt_d)));
        mem_a_hit = mem_regwrite && (mem_wreg != '0) && (mem_wreg == rs_d);
        mem_b_hit = mem_regwrite && (mem_wreg != '0) && rt_used && (mem_wreg == rt_d);
        m_mem     = mem_a_hit || mem_b_hit;

        // EX-stage producer is the younger one, so its latency decides.
        need_o = 2'd0;
        if (m_ex) begin
            need_o = ex_memtoreg ? 2'd2 : 2'd1;
        end else if (m_mem && mem_memtoreg) begin
            need_o = 2'd1;
        end

        fwd_a_d = mem_a_hit && !mem_memtoreg;
        fwd_b_d = mem_b_hit && !mem_memtoreg;
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Decode-stage sequencer for the early-branch comparator.
//   Stalls IF/ID and bubbles EX while a branch operand is still in flight,
//   selects MEM->D forwarding, gates the comparator result into pcsrc_d and
//   flushes IF/ID on a taken branch. Keeps wrap-around statistics counters.
// Ports:
//   clk, rst (async, active-high)
//   branch_d, rs_d, rt_d, br_taken_d                  : decode-stage branch
//   ex_regwrite, ex_memtoreg, ex_wreg                 : EX-stage producer
//   mem_regwrite, mem_memtoreg, mem_wreg              : MEM-stage producer
//   stat_clr                                          : clear statistics
//   stall_f, stall_d, flush_e, flush_d, fwd_a_d, fwd_b_d, pcsrc_d : control
//   branch_cnt, taken_cnt, stall_cnt                  : statistics
module branch_resolve_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned REG_W = REG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       branch_d,
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic             br_taken_d,
    input  logic             ex_regwrite,
    input  logic             ex_memtoreg,
    input  logic [REG_W-1:0] ex_wreg,
    input  logic             mem_regwrite,
    input  logic             mem_memtoreg,
    input  logic [REG_W-1:0] mem_wreg,
    input  logic             stat_clr,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_e,
    output logic             flush_d,
    output logic             fwd_a_d,
    output logic             fwd_b_d,
    output logic             pcsrc_d,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    br_state_e        state_q, state_d;
    logic [1:0]       need;
    logic             fwd_a_raw;
    logic             fwd_b_raw;
    logic             is_br;
    logic             stall;
    logic             resolving;
    logic             taken;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    branch_hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard (
        .branch_d     (branch_d),
        .rs_d         (rs_d),
        .rt_d         (rt_d),
        .ex_regwrite  (ex_regwrite),
        .ex_memtoreg  (ex_memtoreg),
        .ex_wreg      (ex_wreg),
        .mem_regwrite (mem_regwrite),
        .mem_memtoreg (mem_memtoreg),
        .mem_wreg     (mem_wreg),
        .need_o       (need),
        .fwd_a_d      (fwd_a_raw),
        .fwd_b_d      (fwd_b_raw)
    );

    // Outputs are combinational on the current state; rst forces them low
    // immediately so an in-progress stall is dropped without waiting a cycle.
    always_comb begin
        is_br     = is_branch(branch_d);
        stall     = !rst && (((state_q == ST_IDLE) && is_br && (need != 2'd0)) ||
                             (state_q == ST_STALL1));
        resolving = !rst && (((state_q == ST_IDLE) && is_br && (need == 2'd0)) ||
                             ((state_q == ST_RESOLVE) && is_br));
        taken     = resolving && br_taken_d;

        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (is_br && need[1]) begin
                    state_d = ST_STALL1;
                end else if (is_br && need[0]) begin
                    state_d = ST_RESOLVE;
                end
            end
            ST_STALL1:  state_d = ST_RESOLVE;
            ST_RESOLVE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        branch_cnt_d = branch_cnt_q + {{(CNT_W-1){1'b0}}, resolving};
        taken_cnt_d  = taken_cnt_q  + {{(CNT_W-1){1'b0}}, taken};
        stall_cnt_d  = stall_cnt_q  + {{(CNT_W-1){1'b0}}, stall};
        if (stat_clr) begin
            branch_cnt_d = '0;
            taken_cnt_d  = '0;
            stall_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign stall_f    = stall;
    assign stall_d    = stall;
    assign flush_e    = stall;
    assign pcsrc_d    = taken;
    assign flush_d    = taken;
    assign fwd_a_d    = fwd_a_raw && !rst;
    assign fwd_b_d    = fwd_b_raw && !rst;
    assign branch_cnt = branch_cnt_q;
    assign taken_cnt  = taken_cnt_q;
    assign stall_cnt  = stall_cnt_q;

endmodule
